// File: rtl/csr_exec_stage_if.sv
// Purpose: bundles the EX-side instruction fields, the CSR regfile ports and the WB outputs of csr_exec_stage.
// Latency: none; this is a plain signal bundle.
// Backpressure: stall_i travels on this bundle. Upstream holds the EX instruction while stall_i is high.
interface csr_exec_stage_if #(
  parameter int COUNT_WIDTH = 32
);
  // EX stage instruction fields
  logic                   ex_valid_i;
  logic [2:0]             ex_funct3_i;
  logic [11:0]            ex_csr_addr_i;
  logic [4:0]             ex_rs1_idx_i;
  logic [31:0]            ex_rs1_data_i;
  logic [4:0]             ex_rd_idx_i;
  logic                   stall_i;
  logic                   flush_i;

  // CSR regfile read port (combinational)
  logic [11:0]            csr_read_addr_o;
  logic [31:0]            csr_data_read_i;

  // CSR regfile write port (registered)
  logic                   csr_write_en_o;
  logic [11:0]            csr_write_addr_o;
  logic [31:0]            csr_write_data_o;

  // GPR write-back (registered)
  logic                   wb_rd_we_o;
  logic [4:0]             wb_rd_idx_o;
  logic [31:0]            wb_rd_data_o;

  // Committed CSR write counter
  logic [COUNT_WIDTH-1:0] csr_wr_count_o;

  // Stage side: consumes the EX fields and the read data, and drives everything else
  modport slave (
    input  ex_valid_i, ex_funct3_i, ex_csr_addr_i, ex_rs1_idx_i, ex_rs1_data_i, ex_rd_idx_i,
    input  stall_i, flush_i, csr_data_read_i,
    output csr_read_addr_o, csr_write_en_o, csr_write_addr_o, csr_write_data_o,
    output wb_rd_we_o, wb_rd_idx_o, wb_rd_data_o, csr_wr_count_o
  );

  // Pipeline/regfile side: the mirror image of slave
  modport master (
    output ex_valid_i, ex_funct3_i, ex_csr_addr_i, ex_rs1_idx_i, ex_rs1_data_i, ex_rd_idx_i,
    output stall_i, flush_i, csr_data_read_i,
    input  csr_read_addr_o, csr_write_en_o, csr_write_addr_o, csr_write_data_o,
    input  wb_rd_we_o, wb_rd_idx_o, wb_rd_data_o, csr_wr_count_o
  );
endinterface

// File: rtl/csr_exec_stage.sv
// Purpose: executes Zicsr read-modify-write ops and bypasses the pending WB write. It also counts committed CSR writes.
// Latency: EX is read combinationally. The result is registered into a one-deep WB stage, and the regfile commits it one edge later.
// Backpressure: stall_i or flush_i loads a bubble into WB. A stalled instruction is re-presented by upstream.
module csr_exec_stage #(
  parameter int CSR_ADDR_LEN = 4,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  csr_exec_stage_if.slave  bus
);

  typedef struct packed {
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
  } wb_t;

  wb_t                    wb_d, wb_q;
  logic [COUNT_WIDTH-1:0] cnt_d, cnt_q;

  logic        ex_op;
  logic        ex_hit;
  logic        ex_wr;
  logic        ex_rdw;
  logic [31:0] ex_src;
  logic [31:0] ex_old;
  logic [31:0] ex_new;

  // The regfile reads combinationally at the EX address
  assign bus.csr_read_addr_o = bus.ex_csr_addr_i;

  // EX datapath: pick the source, bypass the WB write on an aliased address, and apply the RW/RS/RC op
  always_comb begin
    ex_op  = bus.ex_valid_i && (bus.ex_funct3_i[1:0] != 2'b00);
    ex_src = bus.ex_funct3_i[2] ? {27'b0, bus.ex_rs1_idx_i} : bus.ex_rs1_data_i;
    // The regfile decodes only the low address bits, so the bypass compares only those bits too
    ex_hit = wb_q.csr_we &&
             (wb_q.csr_addr[CSR_ADDR_LEN-1:0] == bus.ex_csr_addr_i[CSR_ADDR_LEN-1:0]);
    ex_old = ex_hit ? wb_q.csr_data : bus.csr_data_read_i;
    ex_new = ex_old;
    case (bus.ex_funct3_i[1:0])
      2'b01:   ex_new = ex_src;
      2'b10:   ex_new = ex_old | ex_src;
      2'b11:   ex_new = ex_old & ~ex_src;
      default: ex_new = ex_old;
    endcase
    // Set/clear ops with a zero source must not write. This avoids side effects on read-only CSRs.
    ex_wr  = ex_op && ((bus.ex_funct3_i[1:0] == 2'b01) || (bus.ex_rs1_idx_i != 5'd0));
    ex_rdw = ex_op && (bus.ex_rd_idx_i != 5'd0);
  end

  // Next WB entry: a bubble unless an op is accepted this cycle
  always_comb begin
    wb_d = '0;
    if (!bus.stall_i && !bus.flush_i && ex_op) begin
      wb_d.csr_we   = ex_wr;
      wb_d.csr_addr = bus.ex_csr_addr_i;
      wb_d.csr_data = ex_new;
      wb_d.rd_we    = ex_rdw;
      wb_d.rd_idx   = bus.ex_rd_idx_i;
      wb_d.rd_data  = ex_old;
    end
  end

  // The counter advances on the edge where the regfile commits the live WB write
  always_comb begin
    cnt_d = cnt_q + COUNT_WIDTH'(wb_q.csr_we);
  end

  // WB and counter state. Reset drops any pending write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.csr_write_en_o   = wb_q.csr_we;
  assign bus.csr_write_addr_o = wb_q.csr_addr;
  assign bus.csr_write_data_o = wb_q.csr_data;
  assign bus.wb_rd_we_o       = wb_q.rd_we;
  assign bus.wb_rd_idx_o      = wb_q.rd_idx;
  assign bus.wb_rd_data_o     = wb_q.rd_data;
  assign bus.csr_wr_count_o   = cnt_q;

endmodule
